// File: rtl/pattern_sweep_capture.sv
// Pattern sweep engine: steps a stimulus through every N_IN-bit pattern
// (binary or Gray order), waits SETTLE cycles, captures {stim, resp} as a
// record, folds it into a 16-bit MISR and hands it out over valid/ready.
module pattern_sweep_capture #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter int GRAY   = 0
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       stim,
  input  logic [N_OUT-1:0]      resp,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [N_IN+N_OUT-1:0] rec_data,
  output logic [15:0]           signature,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = N_IN + N_OUT;
  // idx carries one spare MSB so the terminal compare never wraps
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, EMIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d, idx_inc;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [RW-1:0]   rec_data_q, rec_data_d;
  logic            rec_valid_q, rec_valid_d;
  logic [15:0]     sig_q, sig_d, cap_x, sig_step;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;

  // Pattern generator: binary index or its Gray-code equivalent
  function automatic logic [N_IN-1:0] pat(input logic [N_IN-1:0] b);
    return (GRAY != 0) ? (b ^ (b >> 1)) : b;
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stim_d      = stim_q;
    rec_data_d  = rec_data_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    idx_inc     = idx_q + 1'b1;
    cap_x       = '0;
    cap_x[RW-1:0] = {stim_q, resp};
    sig_step    = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ cap_x;

    case (state_q)
      IDLE, DONE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          state_d = APPLY;
          idx_d   = '0;
          stim_d  = pat('0);
          sig_d   = 16'hFFFF;
        end
      end
      APPLY: begin
        cnt_d   = 4'(SETTLE);
        state_d = (SETTLE == 0) ? CAPTURE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = CAPTURE;
      end
      CAPTURE: begin
        rec_data_d = {stim_q, resp};
        sig_d      = sig_step;
        state_d    = EMIT;
      end
      EMIT: begin
        if (rec_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            stim_d  = pat(idx_inc[N_IN-1:0]);
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort drops back to IDLE with the signature frozen
    if (abort && busy_q) begin
      state_d    = IDLE;
      idx_d      = idx_q;
      stim_d     = stim_q;
      rec_data_d = rec_data_q;
      sig_d      = sig_q;
    end

    rec_valid_d = (state_d == EMIT);
    busy_d      = !(state_d inside {IDLE, DONE});
    done_d      = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stim_q      <= '0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
      sig_q       <= 16'hFFFF;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stim_q      <= stim_d;
      rec_data_q  <= rec_data_d;
      rec_valid_q <= rec_valid_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign stim      = stim_q;
  assign rec_data  = rec_data_q;
  assign rec_valid = rec_valid_q;
  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Bench for pattern_sweep_capture: three instances (binary N_IN=4, N_IN=1,
// Gray N_IN=4 with a 2-bit response and SETTLE=2).
module tb_pattern_sweep_capture;

  logic CK = 1'b0;
  logic reset = 1'b0;
  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc++;

  int n_chk = 0;
  int n_err = 0;

  // instance 0: N_IN=4 N_OUT=1 SETTLE=1 GRAY=0, resp = stim[0]^stim[3]
  logic start0, abort0, ready0, valid0, busy0, done0, resp0;
  logic [3:0] stim0;
  logic [4:0] data0;
  logic [15:0] sig0;
  assign resp0 = stim0[0] ^ stim0[3];
  pattern_sweep_capture #(.N_IN(4), .N_OUT(1), .SETTLE(1), .GRAY(0)) u0 (
    .CK(CK), .reset(reset), .start(start0), .abort(abort0), .stim(stim0),
    .resp(resp0), .rec_valid(valid0), .rec_ready(ready0), .rec_data(data0),
    .signature(sig0), .busy(busy0), .done(done0));

  // instance 1: N_IN=1 N_OUT=1, resp tied 0
  logic start1, abort1, ready1, valid1, busy1, done1;
  logic [0:0] stim1, resp1;
  logic [1:0] data1;
  logic [15:0] sig1;
  assign resp1 = 1'b0;
  pattern_sweep_capture #(.N_IN(1), .N_OUT(1), .SETTLE(1), .GRAY(0)) u1 (
    .CK(CK), .reset(reset), .start(start1), .abort(abort1), .stim(stim1),
    .resp(resp1), .rec_valid(valid1), .rec_ready(ready1), .rec_data(data1),
    .signature(sig1), .busy(busy1), .done(done1));

  // instance 2: N_IN=4 N_OUT=2 SETTLE=2 GRAY=1, resp from a random lookup
  logic start2, abort2, ready2, valid2, busy2, done2;
  logic [3:0] stim2;
  logic [1:0] resp2;
  logic [5:0] data2;
  logic [15:0] sig2;
  logic [1:0] lut [16];
  assign resp2 = lut[stim2];
  pattern_sweep_capture #(.N_IN(4), .N_OUT(2), .SETTLE(2), .GRAY(1)) u2 (
    .CK(CK), .reset(reset), .start(start2), .abort(abort2), .stim(stim2),
    .resp(resp2), .rec_valid(valid2), .rec_ready(ready2), .rec_data(data2),
    .signature(sig2), .busy(busy2), .done(done2));

  typedef struct {
    logic       ready;
    logic [4:0] exp;
    int         gap;
  } vec_t;
  vec_t tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  // wait (bounded) for instance 0 to present a record
  task automatic wait0(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CK);
      if (valid0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge CK);
    start0 = 1'b0;
  endtask

  initial begin
    bit ok;
    int last, got, seen;
    logic [15:0] esig, hold_sig;
    logic [5:0] held, e2;
    bit stalled;
    logic [5:0] q2 [$];

    start0 = 0; abort0 = 0; ready0 = 0;
    start1 = 0; abort1 = 0; ready1 = 0;
    start2 = 0; abort2 = 0; ready2 = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = i[3:0];
      tab[i].ready = 1'b1;
      tab[i].exp   = {p, p[0] ^ p[3]};
      tab[i].gap   = (i == 0) ? 0 : 4;
      lut[i]       = 2'($urandom_range(0, 3));
    end

    // ---- reset state
    repeat (2) @(negedge CK);
    chk("rst stim", stim0, 0);
    chk("rst rec_data", data0, 0);
    chk("rst rec_valid", valid0, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst signature", sig0, 16'hFFFF);
    reset = 1'b1;
    @(negedge CK);

    // ---- table-driven full binary sweep
    ready0 = 1'b1;
    pulse_start0();
    esig = 16'hFFFF;
    last = 0;
    for (int i = 0; i < 16; i++) begin
      ready0 = tab[i].ready;
      wait0(ok);
      chk("tbl timeout", ok, 1);
      if (!ok) break;
      chk("tbl rec_data", data0, tab[i].exp);
      if (i > 0) chk("tbl gap", cyc - last, tab[i].gap);
      last = cyc;
      esig = misr(esig, 16'(tab[i].exp));
      chk("tbl signature", sig0, esig);
    end
    @(negedge CK);
    chk("tbl done", done0, 1);
    chk("tbl busy", busy0, 0);
    chk("tbl valid after last", valid0, 0);
    repeat (3) @(negedge CK);
    chk("tbl done holds", done0, 1);
    chk("tbl signature holds", sig0, esig);

    // ---- N_IN=1: two records, known signature
    ready1 = 1'b1;
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge CK);
        if (valid1) ok = 1'b1;
      end
      chk("n1 timeout", ok, 1);
      chk("n1 rec_data", data1, (k == 0) ? 2'b00 : 2'b10);
    end
    @(negedge CK);
    chk("n1 signature", sig1, 16'hCF9D);
    chk("n1 done", done1, 1);

    // ---- Gray sweep, random backpressure, scoreboard
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b, g;
      b = k[3:0];
      g = b ^ (b >> 1);
      q2.push_back({g, lut[g]});
    end
    esig = 16'hFFFF;
    foreach (q2[k]) esig = misr(esig, 16'(q2[k]));
    start2 = 1'b1;
    @(negedge CK);
    start2 = 1'b0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int t = 0; t < 600 && got < 16; t++) begin
      @(negedge CK);
      if (valid2) begin
        if (stalled) chk("gray stall stable", data2, held);
        ready2 = ($urandom_range(0, 2) != 0);
        if (ready2) begin
          e2 = q2.pop_front();
          chk("gray rec_data", data2, e2);
          chk("gray stim", stim2, e2[5:2]);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = data2;
        end
      end else begin
        ready2 = ($urandom_range(0, 1) != 0);
      end
    end
    chk("gray record count", got, 16);
    repeat (2) @(negedge CK);
    chk("gray done", done2, 1);
    chk("gray no extra record", valid2, 0);
    chk("gray signature", sig2, esig);

    // ---- backpressure on pattern 3, then abort on pattern 7 EMIT
    ready0 = 1'b1;
    pulse_start0();
    chk("restart signature", sig0, 16'hFFFF);
    chk("restart done", done0, 0);
    chk("restart stim", stim0, 0);
    for (int i = 0; i < 8; i++) begin
      wait0(ok);
      chk("bp timeout", ok, 1);
      if (!ok) break;
      chk("bp rec_data", data0, tab[i].exp);
      if (i == 3) begin
        ready0 = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge CK);
          chk("bp valid held", valid0, 1);
          chk("bp data held", data0, tab[3].exp);
        end
        ready0 = 1'b1;
      end
      if (i == 7) begin
        hold_sig = sig0;
        abort0 = 1'b1;
        ready0 = 1'b0;
        @(negedge CK);
        abort0 = 1'b0;
        chk("abort valid", valid0, 0);
        chk("abort busy", busy0, 0);
        chk("abort done", done0, 0);
        chk("abort signature", sig0, hold_sig);
      end
    end
    @(negedge CK);
    chk("abort stays idle", busy0, 0);

    // restart after abort begins at pattern 0
    ready0 = 1'b1;
    pulse_start0();
    chk("post-abort signature", sig0, 16'hFFFF);
    wait0(ok);
    chk("post-abort timeout", ok, 1);
    chk("post-abort first record", data0, tab[0].exp);

    // abort+start together while busy
    @(negedge CK);
    abort0 = 1'b1;
    start0 = 1'b1;
    @(negedge CK);
    abort0 = 1'b0;
    start0 = 1'b0;
    chk("abort+start busy", busy0, 0);
    chk("abort+start valid", valid0, 0);
    chk("abort+start done", done0, 0);
    @(negedge CK);
    chk("abort+start stays idle", busy0, 0);

    // abort+start together while idle: start is not taken
    abort0 = 1'b1;
    start0 = 1'b1;
    @(negedge CK);
    abort0 = 1'b0;
    start0 = 1'b0;
    chk("idle abort+start ignored", busy0, 0);

    // ---- reset pulse during WAIT of pattern 9
    ready0 = 1'b1;
    pulse_start0();
    for (int i = 0; i < 9; i++) begin
      wait0(ok);
      chk("rst-mid timeout", ok, 1);
      if (!ok) break;
      chk("rst-mid rec_data", data0, tab[i].exp);
    end
    @(negedge CK);            // APPLY of pattern 9
    @(negedge CK);            // WAIT of pattern 9
    chk("rst-mid in wait busy", busy0, 1);
    chk("rst-mid in wait stim", stim0, 9);
    reset = 1'b0;
    #1;
    chk("rst-mid stim", stim0, 0);
    chk("rst-mid rec_data", data0, 0);
    chk("rst-mid valid", valid0, 0);
    chk("rst-mid busy", busy0, 0);
    chk("rst-mid done", done0, 0);
    chk("rst-mid signature", sig0, 16'hFFFF);
    @(negedge CK);
    reset = 1'b1;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CK);
      if (valid0 || busy0) seen++;
    end
    chk("rst-mid no activity", seen, 0);
    pulse_start0();
    wait0(ok);
    chk("rst-mid restart timeout", ok, 1);
    chk("rst-mid restart record", data0, tab[0].exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
